// File: rtl/axis_packet_arbiter_pkg.sv
// Shared widths, abort sideband value and FSM encoding for the packet-atomic AXIS arbiter.
package axis_arb_pkg;
  localparam int AXIS_DATA_W = 32;
  localparam int AXIS_KEEP_W = 4;
  localparam int AXIS_USER_W = 8;
  localparam logic [AXIS_USER_W-1:0] ABORT_TUSER = 8'hFF;

  typedef enum logic [1:0] {IDLE, PASS, ABORT, DRAIN} arb_state_t;
endpackage

// File: rtl/axis_packet_arbiter_if.sv
// N_SRC packet sources in, one narrow AXIS sink out, plus grant/status sideband.
interface axis_packet_arbiter_if #(
  parameter int N_SRC = 4
);
  import axis_arb_pkg::*;
  localparam int IDX_W = $clog2(N_SRC);

  logic [N_SRC*AXIS_DATA_W-1:0] sAxiStreamTdata;
  logic [N_SRC*AXIS_KEEP_W-1:0] sAxiStreamTkeep;
  logic [N_SRC*AXIS_USER_W-1:0] sAxiStreamTuser;
  logic [N_SRC-1:0]             sAxiStreamTlast;
  logic [N_SRC-1:0]             sAxiStreamTvalid;
  logic [N_SRC-1:0]             sAxiStreamTready;
  logic [AXIS_DATA_W-1:0]       mAxiStreamTdata;
  logic [AXIS_KEEP_W-1:0]       mAxiStreamTkeep;
  logic [AXIS_USER_W-1:0]       mAxiStreamTuser;
  logic                         mAxiStreamTlast;
  logic                         mAxiStreamTvalid;
  logic                         mAxiStreamTready;
  logic [IDX_W-1:0]             mSourceId;
  logic                         busy;
  logic                         abortPulse;

  // Arbiter side
  modport master (
    input  sAxiStreamTdata, sAxiStreamTkeep, sAxiStreamTuser, sAxiStreamTlast,
           sAxiStreamTvalid, mAxiStreamTready,
    output sAxiStreamTready, mAxiStreamTdata, mAxiStreamTkeep, mAxiStreamTuser,
           mAxiStreamTlast, mAxiStreamTvalid, mSourceId, busy, abortPulse
  );

  // Sources + sink side
  modport slave (
    output sAxiStreamTdata, sAxiStreamTkeep, sAxiStreamTuser, sAxiStreamTlast,
           sAxiStreamTvalid, mAxiStreamTready,
    input  sAxiStreamTready, mAxiStreamTdata, mAxiStreamTkeep, mAxiStreamTuser,
           mAxiStreamTlast, mAxiStreamTvalid, mSourceId, busy, abortPulse
  );
endinterface

// File: rtl/axis_packet_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request strictly after i_last, wrapping.
module rr_pick #(
  parameter  int N_SRC = 4,
  localparam int IDX_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);
  int w_cand;

  // Walk from farthest to nearest so the nearest requester after i_last wins.
  always_comb begin
    o_found = |i_req;
    o_idx   = '0;
    w_cand  = 0;
    for (int k = N_SRC; k >= 1; k--) begin
      w_cand = (int'(i_last) + k) % N_SRC;
      if (i_req[IDX_W'(w_cand)]) o_idx = IDX_W'(w_cand);
    end
  end
endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-atomic round-robin AXIS arbiter; grant holds until the granted tlast is accepted.
// Optional mid-packet timeout with abort beat and drain: define AXIS_ARB_TIMEOUT_EN.
module axis_packet_arbiter #(
  parameter int N_SRC = 4
`ifdef AXIS_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input logic clk,
  input logic reset,
  axis_packet_arbiter_if.master bus
);
  import axis_arb_pkg::*;
  localparam int IDX_W = $clog2(N_SRC);

  arb_state_t       r_state, w_next;
  logic [IDX_W-1:0] r_grant, r_last_grant, w_pick_idx;
  logic             w_pick_found, w_src_valid, w_src_last, w_src_done;

  rr_pick #(.N_SRC(N_SRC)) u_pick (
    .i_req   (bus.sAxiStreamTvalid),
    .i_last  (r_last_grant),
    .o_found (w_pick_found),
    .o_idx   (w_pick_idx)
  );

  assign w_src_valid = bus.sAxiStreamTvalid[r_grant];
  assign w_src_last  = bus.sAxiStreamTlast[r_grant];
  assign w_src_done  = w_src_valid & w_src_last & bus.mAxiStreamTready;

  assign bus.mSourceId = r_grant;
  assign bus.busy      = (r_state != IDLE);

`ifdef AXIS_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] r_cnt;
  logic             w_timeout;

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counts consecutive idle cycles of the granted source while passing a packet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              r_cnt <= '0;
    else if (r_state == PASS && !w_src_valid) r_cnt <= r_cnt + CNT_W'(1);
    else                                    r_cnt <= '0;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= IDX_W'(N_SRC - 1);
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_pick_found) r_grant <= w_pick_idx;
      if (r_state != IDLE && w_next == IDLE) r_last_grant <= r_grant;
    end
  end

  always_comb begin
    w_next               = r_state;
    bus.mAxiStreamTvalid = 1'b0;
    bus.mAxiStreamTdata  = '0;
    bus.mAxiStreamTkeep  = '0;
    bus.mAxiStreamTuser  = '0;
    bus.mAxiStreamTlast  = 1'b0;
    bus.sAxiStreamTready = '0;
    bus.abortPulse       = 1'b0;
    case (r_state)
      IDLE: if (w_pick_found) w_next = PASS;
      PASS: begin
        bus.mAxiStreamTvalid          = w_src_valid;
        bus.mAxiStreamTdata           = bus.sAxiStreamTdata[r_grant*AXIS_DATA_W +: AXIS_DATA_W];
        bus.mAxiStreamTkeep           = bus.sAxiStreamTkeep[r_grant*AXIS_KEEP_W +: AXIS_KEEP_W];
        bus.mAxiStreamTuser           = bus.sAxiStreamTuser[r_grant*AXIS_USER_W +: AXIS_USER_W];
        bus.mAxiStreamTlast           = w_src_last;
        bus.sAxiStreamTready[r_grant] = bus.mAxiStreamTready;
        if (w_src_done) w_next = IDLE;
`ifdef AXIS_ARB_TIMEOUT_EN
        else if (!w_src_valid && w_timeout) w_next = ABORT;
`endif
      end
`ifdef AXIS_ARB_TIMEOUT_EN
      // Synthetic terminator so the consumer sees a closed, empty-keep packet.
      ABORT: begin
        bus.mAxiStreamTvalid = 1'b1;
        bus.mAxiStreamTlast  = 1'b1;
        bus.mAxiStreamTuser  = ABORT_TUSER;
        if (bus.mAxiStreamTready) begin
          bus.abortPulse = 1'b1;
          w_next         = DRAIN;
        end
      end
      DRAIN: begin
        bus.sAxiStreamTready[r_grant] = 1'b1;
        if (w_src_valid && w_src_last) w_next = IDLE;
      end
`endif
      default: w_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Self-checking bench for axis_packet_arbiter: directed scenarios plus a randomized run
// against a transaction-level round-robin model. Timeout scenario needs AXIS_ARB_TIMEOUT_EN.
module tb_axis_packet_arbiter;
  localparam int N = 4;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic [7:0]  user;
    logic        last;
  } beat_t;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    logic [3:0]  keep;
    logic [7:0]  user;
    logic        last;
  } out_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  axis_packet_arbiter_if #(.N_SRC(N)) bus();

`ifdef AXIS_ARB_TIMEOUT_EN
  axis_packet_arbiter #(.N_SRC(N), .TIMEOUT_CYCLES(8)) dut (.clk(clk), .reset(reset), .bus(bus));
`else
  axis_packet_arbiter #(.N_SRC(N)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  beat_t       src_q[N][$];
  out_t        out_q[$];
  logic [N-1:0] hold;
  logic        ds_ready;
  int          ds_mode;   // 0 always ready, 1 random, 2 toggle
  int          seq;
  int          n_checks = 0;
  int          n_pass = 0;

  logic        obs_valid, obs_last, obs_busy, obs_abort, obs_mready;
  logic [1:0]  obs_id;
  logic [31:0] obs_data;
  logic [3:0]  obs_keep;
  logic [7:0]  obs_user;
  logic [N-1:0] obs_sready, obs_svalid, obs_slast;
  logic [31:0] obs_sdata[N];

  task automatic push_pkt(input int src, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = {src[7:0], seq[15:0], k[7:0]};
      b.keep = 4'($urandom);
      b.user = 8'($urandom);
      b.last = (k == len - 1);
      src_q[src].push_back(b);
    end
    seq++;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        bus.sAxiStreamTvalid[i]        = !hold[i];
        bus.sAxiStreamTdata[i*32 +: 32] = src_q[i][0].data;
        bus.sAxiStreamTkeep[i*4 +: 4]   = src_q[i][0].keep;
        bus.sAxiStreamTuser[i*8 +: 8]   = src_q[i][0].user;
        bus.sAxiStreamTlast[i]         = src_q[i][0].last;
      end else begin
        bus.sAxiStreamTvalid[i]        = 1'b0;
        bus.sAxiStreamTdata[i*32 +: 32] = '0;
        bus.sAxiStreamTkeep[i*4 +: 4]   = '0;
        bus.sAxiStreamTuser[i*8 +: 8]   = '0;
        bus.sAxiStreamTlast[i]         = 1'b0;
      end
    end
    bus.mAxiStreamTready = ds_ready;
  endtask

  // One clock: sample at negedge, pop accepted source beats after the edge, redrive.
  task automatic step();
    logic [N-1:0] acc;
    @(negedge clk);
    obs_valid  = bus.mAxiStreamTvalid;
    obs_last   = bus.mAxiStreamTlast;
    obs_id     = bus.mSourceId;
    obs_data   = bus.mAxiStreamTdata;
    obs_keep   = bus.mAxiStreamTkeep;
    obs_user   = bus.mAxiStreamTuser;
    obs_busy   = bus.busy;
    obs_abort  = bus.abortPulse;
    obs_sready = bus.sAxiStreamTready;
    obs_svalid = bus.sAxiStreamTvalid;
    obs_slast  = bus.sAxiStreamTlast;
    obs_mready = bus.mAxiStreamTready;
    for (int i = 0; i < N; i++) obs_sdata[i] = bus.sAxiStreamTdata[i*32 +: 32];
    acc = bus.sAxiStreamTvalid & bus.sAxiStreamTready;
    if (obs_valid && obs_mready)
      out_q.push_back('{id: obs_id, data: obs_data, keep: obs_keep, user: obs_user, last: obs_last});
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) void'(src_q[i].pop_front());
    case (ds_mode)
      1:       ds_ready = ($urandom_range(3) != 0);
      2:       ds_ready = ~ds_ready;
      default: ds_ready = 1'b1;
    endcase
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < N; i++) src_q[i].delete();
    hold = '0;
    ds_mode = 0;
    ds_ready = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    out_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    hold = '0;
    ds_mode = 0;
    ds_ready = 1'b1;
    for (int i = 0; i < N; i++) push_pkt(i, 2);
    drive();
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (bus.mAxiStreamTvalid !== 1'b0) $display("FAIL rst_mvalid got=%b want=0", bus.mAxiStreamTvalid);
      else n_pass++;
      n_checks++;
      if (bus.sAxiStreamTready !== 4'b0) $display("FAIL rst_sready got=%b want=0000", bus.sAxiStreamTready);
      else n_pass++;
      n_checks++;
      if ({bus.busy, bus.abortPulse, bus.mSourceId} !== 4'b0)
        $display("FAIL rst_status got busy=%b abort=%b id=%0d want all 0", bus.busy, bus.abortPulse, bus.mSourceId);
      else n_pass++;
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    n_checks++;
    if ({obs_valid, obs_busy} !== 2'b00) $display("FAIL rst_first_idle got valid=%b busy=%b want 0 0", obs_valid, obs_busy);
    else n_pass++;
    step();
    n_checks++;
    if ({obs_valid, obs_id} !== {1'b1, 2'd0}) $display("FAIL rst_first_grant got valid=%b id=%0d want 1 0", obs_valid, obs_id);
    else n_pass++;
  endtask

  task automatic test_single_src();
    beat_t exp[$];
    logic  e;
    do_reset();
    push_pkt(2, 3);
    exp = src_q[2];
    drive();
    for (int c = 0; c < 5; c++) begin
      step();
      e = (c >= 1 && c <= 3);
      n_checks++;
      if ({obs_valid, obs_busy} !== {e, e})
        $display("FAIL single_vb c=%0d got valid=%b busy=%b want %b %b", c, obs_valid, obs_busy, e, e);
      else n_pass++;
      if (e) begin
        n_checks++;
        if ({obs_id, obs_data, obs_last} !== {2'd2, exp[c-1].data, (c == 3)})
          $display("FAIL single_beat c=%0d got id=%0d data=%h last=%b want 2 %h %b", c, obs_id, obs_data, obs_last, exp[c-1].data, (c == 3));
        else n_pass++;
      end
    end
  endtask

  task automatic test_round_robin();
    logic       e_valid;
    logic [1:0] e_id;
    do_reset();
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) push_pkt(i, 2);
    drive();
    for (int c = 0; c < 15; c++) begin
      step();
      e_valid = (c % 3) != 0;
      e_id    = 2'((c / 3) % N);
      n_checks++;
      if (obs_valid !== e_valid || (e_valid && obs_id !== e_id))
        $display("FAIL rr_order c=%0d got valid=%b id=%0d want %b %0d", c, obs_valid, obs_id, e_valid, e_id);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    beat_t exp[$];
    int    c;
    do_reset();
    push_pkt(1, 4);
    push_pkt(3, 2);
    exp = src_q[1];
    ds_mode = 2;
    ds_ready = 1'b1;
    drive();
    c = 0;
    while (out_q.size() < 4 && c < 20) begin
      step();
      n_checks++;
      if (obs_sready !== (c == 0 ? 4'b0000 : {2'b00, obs_mready, 1'b0}))
        $display("FAIL bp_sready c=%0d got=%b mready=%b", c, obs_sready, obs_mready);
      else n_pass++;
      c++;
    end
    n_checks++;
    if (out_q.size() !== 4) $display("FAIL bp_count got=%0d want=4", out_q.size());
    else n_pass++;
    for (int k = 0; k < out_q.size() && k < 4; k++) begin
      n_checks++;
      if ({out_q[k].id, out_q[k].data, out_q[k].keep, out_q[k].user, out_q[k].last} !==
          {2'd1, exp[k].data, exp[k].keep, exp[k].user, exp[k].last})
        $display("FAIL bp_beat k=%0d got id=%0d data=%h want 1 %h", k, out_q[k].id, out_q[k].data, exp[k].data);
      else n_pass++;
    end
  endtask

  task automatic test_no_preempt();
    beat_t exp0[$];
    beat_t exp3[$];
    int    c;
    do_reset();
    push_pkt(0, 4);
    exp0 = src_q[0];
    drive();
    step();
    step();
    push_pkt(3, 2);
    exp3 = src_q[3];
    drive();
    c = 0;
    while (out_q.size() < 6 && c < 30) begin
      step();
      c++;
    end
    n_checks++;
    if (out_q.size() !== 6) $display("FAIL np_count got=%0d want=6", out_q.size());
    else n_pass++;
    for (int k = 0; k < out_q.size() && k < 6; k++) begin
      n_checks++;
      if (k < 4 ? ({out_q[k].id, out_q[k].data} !== {2'd0, exp0[k].data})
                : ({out_q[k].id, out_q[k].data} !== {2'd3, exp3[k-4].data}))
        $display("FAIL np_order k=%0d got id=%0d data=%h", k, out_q[k].id, out_q[k].data);
      else n_pass++;
    end
  endtask

`ifdef AXIS_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int aborts;
    int c;
    bit released;
    do_reset();
    push_pkt(1, 4);
    drive();
    aborts = 0;
    released = 0;
    c = 0;
    while (c < 60) begin
      step();
      c++;
      if (obs_abort) aborts++;
      if (!released && aborts == 0 && src_q[1].size() == 2 && !hold[1]) begin
        hold[1] = 1'b1;
        drive();
      end
      if (aborts > 0 && hold[1]) begin
        hold[1] = 1'b0;
        released = 1;
        drive();
      end
      if (released && src_q[1].size() == 0 && !obs_busy) break;
    end
    n_checks++;
    if (c >= 60) $display("FAIL to_budget got cycles=%0d want <60", c);
    else n_pass++;
    n_checks++;
    if (aborts !== 1) $display("FAIL to_pulse got=%0d want=1", aborts);
    else n_pass++;
    n_checks++;
    if (out_q.size() !== 3) $display("FAIL to_count got=%0d want=3", out_q.size());
    else n_pass++;
    if (out_q.size() == 3) begin
      n_checks++;
      if ({out_q[2].id, out_q[2].data, out_q[2].keep, out_q[2].user, out_q[2].last} !==
          {2'd1, 32'h0, 4'h0, 8'hFF, 1'b1})
        $display("FAIL to_beat got keep=%h user=%h last=%b data=%h want 0 ff 1 0",
                 out_q[2].keep, out_q[2].user, out_q[2].last, out_q[2].data);
      else n_pass++;
    end
    n_checks++;
    if (src_q[1].size() !== 0) $display("FAIL to_drain got left=%0d want=0", src_q[1].size());
    else n_pass++;
  endtask
`endif

  task automatic test_reset_mid();
    int c;
    do_reset();
    push_pkt(2, 4);
    drive();
    step();
    step();
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.mAxiStreamTvalid, bus.sAxiStreamTready, bus.busy, bus.abortPulse, bus.mSourceId} !== '0)
      $display("FAIL rm_outputs got valid=%b sready=%b busy=%b id=%0d want 0",
               bus.mAxiStreamTvalid, bus.sAxiStreamTready, bus.busy, bus.mSourceId);
    else n_pass++;
    push_pkt(0, 2);
    drive();
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_q.delete();
    c = 0;
    while (out_q.size() == 0 && c < 10) begin
      step();
      c++;
    end
    n_checks++;
    if (out_q.size() == 0) $display("FAIL rm_budget got no beat want src0 beat");
    else if (out_q[0].id !== 2'd0) $display("FAIL rm_prio got id=%0d want=0", out_q[0].id);
    else n_pass++;
  endtask

  task automatic test_random();
    int          m_owner;
    int          m_last;
    int          nxt;
    logic        e_valid;
    logic [N-1:0] e_ready;
    do_reset();
    ds_mode = 1;
    m_owner = -1;
    m_last = N - 1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (src_q[i].size() == 0 && $urandom_range(2) == 0) push_pkt(i, $urandom_range(4, 1));
        hold[i] = ($urandom_range(7) == 0);
      end
      drive();
      step();
      e_valid = 1'b0;
      e_ready = '0;
      if (m_owner < 0) begin
        nxt = -1;
        for (int k = 1; k <= N && nxt < 0; k++)
          if (obs_svalid[(m_last + k) % N]) nxt = (m_last + k) % N;
        m_owner = nxt;
      end else begin
        e_valid = obs_svalid[m_owner];
        e_ready[m_owner] = obs_mready;
        n_checks++;
        if ({obs_valid, obs_sready} !== {e_valid, e_ready})
          $display("FAIL rnd_hs cyc=%0d got valid=%b sready=%b want %b %b", cyc, obs_valid, obs_sready, e_valid, e_ready);
        else n_pass++;
        if (e_valid) begin
          n_checks++;
          if ({obs_id, obs_data, obs_last} !== {2'(m_owner), obs_sdata[m_owner], obs_slast[m_owner]})
            $display("FAIL rnd_data cyc=%0d got id=%0d data=%h want %0d %h", cyc, obs_id, obs_data, m_owner, obs_sdata[m_owner]);
          else n_pass++;
        end
        if (e_valid && obs_mready && obs_slast[m_owner]) begin
          m_last = m_owner;
          m_owner = -1;
        end
      end
    end
  endtask

  initial begin
    seq = 0;
    hold = '0;
    ds_mode = 0;
    ds_ready = 1'b1;
    drive();
    test_reset();
    test_single_src();
    test_round_robin();
    test_backpressure();
    test_no_preempt();
`ifdef AXIS_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
